// File: rtl/ariane_pkg.sv
// ariane_pkg: shared types and default sizing for the store translation queue.
// Holds the queue entry record, the atomic-operation encoding and the default
// parameter values used by st_xlate_queue and its interface.
package ariane_pkg;

    localparam int unsigned XQ_DEPTH   = 4;
    localparam int unsigned XQ_DATA_W  = 64;
    localparam int unsigned XQ_VADDR_W = 64;
    localparam int unsigned XQ_PADDR_W = 56;
    localparam int unsigned XQ_TID_W   = 3;
    localparam int unsigned XQ_BE_W    = XQ_DATA_W / 8;

    // Atomic memory operation encoding carried alongside each entry
    typedef enum logic [3:0] {
        AMO_NONE = 4'h0,
        AMO_LR   = 4'h1,
        AMO_SC   = 4'h2,
        AMO_SWAP = 4'h3,
        AMO_ADD  = 4'h4,
        AMO_AND  = 4'h5,
        AMO_OR   = 4'h6,
        AMO_XOR  = 4'h7,
        AMO_MAX  = 4'h8,
        AMO_MAXU = 4'h9,
        AMO_MIN  = 4'hA,
        AMO_MINU = 4'hB
    } amo_t;

    // One pending store; field widths follow the default sizing above.
    // Payload is captured at enqueue, paddr/ex are filled in on a TLB hit.
    typedef struct packed {
        logic [XQ_VADDR_W-1:0] vaddr;
        logic [XQ_PADDR_W-1:0] paddr;
        logic [XQ_DATA_W-1:0]  data;
        logic [XQ_BE_W-1:0]    be;
        logic [1:0]            size;
        logic [XQ_TID_W-1:0]   trans_id;
        logic                  ex;
        logic                  is_amo;
        amo_t                  amo_op;
    } st_entry_t;

endpackage

// File: rtl/st_xlate_queue_if.sv
// st_xlate_queue_if: enqueue, MMU, store-buffer and writeback signal bundle.
// The atomics port (is_amo_i/amo_op_i/amo_valid_o/amo_ready_i/amo_op_o) exists
// only when ST_XLATE_QUEUE_AMO_EN is defined.
// slave = queue side, master = surrounding pipeline side.
interface st_xlate_queue_if
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH   = XQ_DEPTH,
    parameter int unsigned DATA_W  = XQ_DATA_W,
    parameter int unsigned VADDR_W = XQ_VADDR_W,
    parameter int unsigned PADDR_W = XQ_PADDR_W,
    parameter int unsigned TID_W   = XQ_TID_W
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic               flush_i;
    logic               valid_i;
    logic               ready_o;
    logic [VADDR_W-1:0] vaddr_i;
    logic [DATA_W-1:0]  data_i;
    logic [BE_W-1:0]    be_i;
    logic [1:0]         size_i;
    logic [TID_W-1:0]   trans_id_i;

    logic               translation_req_o;
    logic [VADDR_W-1:0] vaddr_o;
    logic               dtlb_hit_i;
    logic [PADDR_W-1:0] paddr_i;
    logic               ex_valid_i;

    logic               sb_valid_o;
    logic               sb_ready_i;
    logic [PADDR_W-1:0] sb_paddr_o;
    logic [DATA_W-1:0]  sb_data_o;
    logic [BE_W-1:0]    sb_be_o;
    logic [1:0]         sb_size_o;

    logic               wb_valid_o;
    logic [TID_W-1:0]   wb_trans_id_o;
    logic               wb_ex_o;

    logic [CNT_W-1:0]   count_o;
    logic               empty_o;

`ifdef ST_XLATE_QUEUE_AMO_EN
    logic               is_amo_i;
    logic [3:0]         amo_op_i;
    logic               amo_valid_o;
    logic               amo_ready_i;
    logic [3:0]         amo_op_o;
`endif

    modport slave (
`ifdef ST_XLATE_QUEUE_AMO_EN
        input  is_amo_i, amo_op_i, amo_ready_i,
        output amo_valid_o, amo_op_o,
`endif
        input  flush_i, valid_i, vaddr_i, data_i, be_i, size_i, trans_id_i,
        input  dtlb_hit_i, paddr_i, ex_valid_i, sb_ready_i,
        output ready_o, translation_req_o, vaddr_o,
        output sb_valid_o, sb_paddr_o, sb_data_o, sb_be_o, sb_size_o,
        output wb_valid_o, wb_trans_id_o, wb_ex_o, count_o, empty_o
    );

    modport master (
`ifdef ST_XLATE_QUEUE_AMO_EN
        output is_amo_i, amo_op_i, amo_ready_i,
        input  amo_valid_o, amo_op_o,
`endif
        output flush_i, valid_i, vaddr_i, data_i, be_i, size_i, trans_id_i,
        output dtlb_hit_i, paddr_i, ex_valid_i, sb_ready_i,
        input  ready_o, translation_req_o, vaddr_o,
        input  sb_valid_o, sb_paddr_o, sb_data_o, sb_be_o, sb_size_o,
        input  wb_valid_o, wb_trans_id_o, wb_ex_o, count_o, empty_o
    );

endinterface

// File: rtl/st_xq_align.sv
// st_xq_align: combinational byte realigner used at enqueue.
// Moves store data and byte enables up to the byte lane selected by the low
// address bits; atomic entries pass through unshifted.
module st_xq_align #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned BE_W   = DATA_W / 8,
    parameter int unsigned OFF_W  = (BE_W > 1) ? $clog2(BE_W) : 1
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [OFF_W-1:0]  offset_i,
    input  logic              is_amo_i,
    output logic [DATA_W-1:0] data_o,
    output logic [BE_W-1:0]   be_o
);

    // Byte-lane shift: data moves by offset*8 bits, enables by offset
    always_comb begin
        data_o = data_i;
        be_o   = be_i;
        if (is_amo_i) begin
            data_o = data_i;
            be_o   = be_i;
        end else begin
            data_o = data_i << {offset_i, 3'b000};
            be_o   = be_i << offset_i;
        end
    end

endmodule

// File: rtl/st_xlate_queue.sv
// st_xlate_queue: in-order store queue sitting between issue and the store buffer.
// Entries are enqueued with their virtual address, translated in order through
// the DTLB port, then pushed to the store buffer (or retired with an exception)
// from the head. Three pointers (enq, xlate, issue) walk one circular array.
// Optional feature macro: ST_XLATE_QUEUE_AMO_EN adds an atomics issue port.
module st_xlate_queue
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH   = XQ_DEPTH,
    parameter int unsigned DATA_W  = XQ_DATA_W,
    parameter int unsigned VADDR_W = XQ_VADDR_W,
    parameter int unsigned PADDR_W = XQ_PADDR_W,
    parameter int unsigned TID_W   = XQ_TID_W
) (
    input logic             clk_i,
    input logic             rst_i,
    st_xlate_queue_if.slave q
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned OFF_W = (BE_W > 1) ? $clog2(BE_W) : 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Storage and queue state
    st_entry_t          mem_r [DEPTH];
    logic [DEPTH-1:0]   valid_r;
    logic [DEPTH-1:0]   xlated_r;
    logic [PTR_W-1:0]   enq_ptr_r;
    logic [PTR_W-1:0]   xlate_ptr_r;
    logic [PTR_W-1:0]   issue_ptr_r;
    logic [CNT_W-1:0]   count_r;

    // Per-cycle decisions
    logic               kill_s;
    logic               ready_s;
    logic               enq_s;
    logic               treq_s;
    logic               xlate_s;
    logic               head_rdy_s;
    logic               head_ex_s;
    logic               head_amo_s;
    logic               sb_valid_s;
    logic               amo_valid_s;
    logic               amo_ready_s;
    logic               ex_pop_s;
    logic               pop_s;
    logic               amo_queued_s;
    logic               is_amo_in_s;
    amo_t               amo_op_in_s;
    st_entry_t          new_e_s;
    logic [DATA_W-1:0]  al_data_s;
    logic [BE_W-1:0]    al_be_s;

`ifdef ST_XLATE_QUEUE_AMO_EN
    assign is_amo_in_s = q.is_amo_i;
    assign amo_op_in_s = amo_t'(q.amo_op_i);
    assign amo_ready_s = q.amo_ready_i;

    // Enqueue is held off for as long as any atomic is still in the queue
    always_comb begin
        amo_queued_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            amo_queued_s = amo_queued_s | (valid_r[i] & mem_r[i].is_amo);
        end
    end

    assign q.amo_valid_o = amo_valid_s;
    assign q.amo_op_o    = mem_r[issue_ptr_r].amo_op;
`else
    logic unused_amo_s;

    assign is_amo_in_s  = 1'b0;
    assign amo_op_in_s  = AMO_NONE;
    assign amo_ready_s  = 1'b0;
    assign amo_queued_s = 1'b0;
    assign unused_amo_s = ^mem_r[issue_ptr_r].amo_op;
`endif

    st_xq_align #(
        .DATA_W (DATA_W),
        .BE_W   (BE_W),
        .OFF_W  (OFF_W)
    ) u_align (
        .data_i   (q.data_i),
        .be_i     (q.be_i),
        .offset_i (q.vaddr_i[OFF_W-1:0]),
        .is_amo_i (is_amo_in_s),
        .data_o   (al_data_s),
        .be_o     (al_be_s)
    );

    // Handshake decisions; flush and reset kill every event in their cycle
    always_comb begin
        kill_s      = rst_i | q.flush_i;
        ready_s     = (count_r < CNT_W'(DEPTH)) && !amo_queued_s;
        enq_s       = q.valid_i && ready_s && !kill_s;

        // The xlate slot needs translation when it holds an entry not yet translated;
        // this also covers the full queue where xlate == enq
        treq_s      = valid_r[xlate_ptr_r] && !xlated_r[xlate_ptr_r];
        xlate_s     = treq_s && q.dtlb_hit_i && !kill_s;

        head_rdy_s  = valid_r[issue_ptr_r] && xlated_r[issue_ptr_r];
        head_ex_s   = mem_r[issue_ptr_r].ex;
        head_amo_s  = mem_r[issue_ptr_r].is_amo;

        sb_valid_s  = head_rdy_s && !head_ex_s && !head_amo_s && !kill_s;
        amo_valid_s = head_rdy_s && !head_ex_s && head_amo_s && !kill_s;
        ex_pop_s    = head_rdy_s && head_ex_s && !kill_s;
        pop_s       = (sb_valid_s && q.sb_ready_i) || (amo_valid_s && amo_ready_s) || ex_pop_s;
    end

    // Record captured on enqueue; paddr/ex are written later by the TLB hit
    always_comb begin
        new_e_s          = '0;
        new_e_s.vaddr    = XQ_VADDR_W'(q.vaddr_i);
        new_e_s.data     = XQ_DATA_W'(al_data_s);
        new_e_s.be       = XQ_BE_W'(al_be_s);
        new_e_s.size     = q.size_i;
        new_e_s.trans_id = XQ_TID_W'(q.trans_id_i);
        new_e_s.is_amo   = is_amo_in_s;
        new_e_s.amo_op   = amo_op_in_s;
    end

    // Pointers, occupancy and per-entry flags; flush and reset both empty the queue
    always_ff @(posedge clk_i) begin
        if (rst_i || q.flush_i) begin
            enq_ptr_r   <= PTR_W'(0);
            xlate_ptr_r <= PTR_W'(0);
            issue_ptr_r <= PTR_W'(0);
            count_r     <= CNT_W'(0);
            valid_r     <= {DEPTH{1'b0}};
            xlated_r    <= {DEPTH{1'b0}};
        end else begin
            if (enq_s) begin
                valid_r[enq_ptr_r]  <= 1'b1;
                xlated_r[enq_ptr_r] <= 1'b0;
                enq_ptr_r           <= enq_ptr_r + PTR_W'(1);
            end
            if (xlate_s) begin
                xlated_r[xlate_ptr_r] <= 1'b1;
                xlate_ptr_r           <= xlate_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                valid_r[issue_ptr_r]  <= 1'b0;
                xlated_r[issue_ptr_r] <= 1'b0;
                issue_ptr_r           <= issue_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(enq_s) - CNT_W'(pop_s);
        end
    end

    // Entry payload: written on enqueue, translation result written on a hit
    always_ff @(posedge clk_i) begin
        if (enq_s) begin
            mem_r[enq_ptr_r] <= new_e_s;
        end
        if (xlate_s) begin
            mem_r[xlate_ptr_r].paddr <= XQ_PADDR_W'(q.paddr_i);
            mem_r[xlate_ptr_r].ex    <= q.ex_valid_i;
        end
    end

    assign q.ready_o           = ready_s;
    assign q.translation_req_o = treq_s;
    assign q.vaddr_o           = VADDR_W'(mem_r[xlate_ptr_r].vaddr);

    assign q.sb_valid_o        = sb_valid_s;
    assign q.sb_paddr_o        = PADDR_W'(mem_r[issue_ptr_r].paddr);
    assign q.sb_data_o         = DATA_W'(mem_r[issue_ptr_r].data);
    assign q.sb_be_o           = BE_W'(mem_r[issue_ptr_r].be);
    assign q.sb_size_o         = mem_r[issue_ptr_r].size;

    assign q.wb_valid_o        = pop_s;
    assign q.wb_trans_id_o     = TID_W'(mem_r[issue_ptr_r].trans_id);
    assign q.wb_ex_o           = ex_pop_s;

    assign q.count_o           = count_r;
    assign q.empty_o           = (count_r == CNT_W'(0));

endmodule

// File: tb/tb_st_xlate_queue.sv
// tb_st_xlate_queue: self-checking bench for st_xlate_queue (default build).
// Directed table of single stores, hand-written multi-cycle corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_st_xlate_queue;
    import ariane_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    st_xlate_queue_if #(.DEPTH(DEPTH), .DATA_W(64), .VADDR_W(64), .PADDR_W(56), .TID_W(3)) bus ();

    st_xlate_queue #(.DEPTH(DEPTH), .DATA_W(64), .VADDR_W(64), .PADDR_W(56), .TID_W(3)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .q     (bus)
    );

    typedef struct {
        logic [63:0] vaddr;
        logic [63:0] data;
        logic [7:0]  be;
        logic [1:0]  size;
        logic [2:0]  tid;
        logic [55:0] paddr;
        logic [63:0] exp_data;
        logic [7:0]  exp_be;
    } vec_t;

    typedef struct {
        logic [63:0] vaddr;
        logic [63:0] data;
        logic [7:0]  be;
        logic [1:0]  size;
        logic [2:0]  tid;
        logic [55:0] paddr;
        bit          xl;
        bit          ex;
    } ment_t;

    vec_t        vecs [6];
    ment_t       mq [$];
    int          n_wb;
    int          n_push;
    int          n_bad;
    int          k;
    logic [2:0]  wb_tids [8];
    logic        wb_exs [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.flush_i    = 1'b0;
        bus.valid_i    = 1'b0;
        bus.vaddr_i    = 64'd0;
        bus.data_i     = 64'd0;
        bus.be_i       = 8'd0;
        bus.size_i     = 2'd0;
        bus.trans_id_i = 3'd0;
        bus.dtlb_hit_i = 1'b0;
        bus.paddr_i    = 56'd0;
        bus.ex_valid_i = 1'b0;
        bus.sb_ready_i = 1'b0;
`ifdef ST_XLATE_QUEUE_AMO_EN
        bus.is_amo_i    = 1'b0;
        bus.amo_op_i    = 4'd0;
        bus.amo_ready_i = 1'b0;
`endif
    endtask

    task automatic set_store(input logic [63:0] va, input logic [63:0] d, input logic [7:0] b,
                             input logic [1:0] sz, input logic [2:0] tid);
        bus.valid_i    = 1'b1;
        bus.vaddr_i    = va;
        bus.data_i     = d;
        bus.be_i       = b;
        bus.size_i     = sz;
        bus.trans_id_i = tid;
    endtask

    // Drain with hit and sb_ready held high, collecting writebacks in order
    task automatic drain(input int cycles);
        n_wb = 0;
        bus.dtlb_hit_i = 1'b1;
        bus.sb_ready_i = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            #1;
            if (bus.wb_valid_o) begin
                if (n_wb < 8) begin
                    wb_tids[n_wb] = bus.wb_trans_id_o;
                    wb_exs[n_wb]  = bus.wb_ex_o;
                end
                if (bus.count_o == 3'd4) chk("full_no_bypass", 64'(bus.ready_o), 64'd0);
                n_wb++;
            end
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{64'h1003, 64'hAB, 8'h01, 2'd0, 3'd5, 56'h8000_1003, 64'hAB00_0000, 8'h08};
        vecs[1] = '{64'h2000, 64'h1122_3344_5566_7788, 8'hFF, 2'd3, 3'd1, 56'h12_0000_2000,
                    64'h1122_3344_5566_7788, 8'hFF};
        vecs[2] = '{64'h3006, 64'hBEEF, 8'h03, 2'd1, 3'd2, 56'h3006, 64'hBEEF_0000_0000_0000, 8'hC0};
        vecs[3] = '{64'h4001, 64'hDEAD_BEEF, 8'h0F, 2'd2, 3'd3, 56'hFF_FFFF_FFFF_4001,
                    64'h0000_00DE_ADBE_EF00, 8'h1E};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFF7, 64'h5A, 8'h01, 2'd0, 3'd7, 56'h7, 64'h5A00_0000_0000_0000, 8'h80};
        vecs[5] = '{64'h6004, 64'hCAFE_BABE, 8'h0F, 2'd2, 3'd0, 56'h6004, 64'hCAFE_BABE_0000_0000, 8'hF0};

        // ---------------- reset ----------------
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", 64'(bus.ready_o), 64'd1);
        chk("rst_empty", 64'(bus.empty_o), 64'd1);
        chk("rst_count", 64'(bus.count_o), 64'd0);
        chk("rst_treq",  64'(bus.translation_req_o), 64'd0);
        chk("rst_sbv",   64'(bus.sb_valid_o), 64'd0);
        chk("rst_wbv",   64'(bus.wb_valid_o), 64'd0);
        @(negedge clk);

        // ---------------- table: single store, latency 2 ----------------
        for (int i = 0; i < 6; i++) begin
            set_store(vecs[i].vaddr, vecs[i].data, vecs[i].be, vecs[i].size, vecs[i].tid);
            #1;
            chk("tbl_ready", 64'(bus.ready_o), 64'd1);
            chk("tbl_treq0", 64'(bus.translation_req_o), 64'd0);
            @(negedge clk);
            idle();
            bus.dtlb_hit_i = 1'b1;
            bus.paddr_i    = vecs[i].paddr;
            #1;
            chk("tbl_treq", 64'(bus.translation_req_o), 64'd1);
            chk("tbl_vaddr", bus.vaddr_o, vecs[i].vaddr);
            chk("tbl_sbv_early", 64'(bus.sb_valid_o), 64'd0);
            chk("tbl_count", 64'(bus.count_o), 64'd1);
            @(negedge clk);
            idle();
            bus.sb_ready_i = 1'b1;
            #1;
            chk("tbl_sbv", 64'(bus.sb_valid_o), 64'd1);
            chk("tbl_paddr", 64'(bus.sb_paddr_o), 64'(vecs[i].paddr));
            chk("tbl_data", bus.sb_data_o, vecs[i].exp_data);
            chk("tbl_be", 64'(bus.sb_be_o), 64'(vecs[i].exp_be));
            chk("tbl_size", 64'(bus.sb_size_o), 64'(vecs[i].size));
            chk("tbl_wbv", 64'(bus.wb_valid_o), 64'd1);
            chk("tbl_tid", 64'(bus.wb_trans_id_o), 64'(vecs[i].tid));
            chk("tbl_wbex", 64'(bus.wb_ex_o), 64'd0);
            @(negedge clk);
            idle();
            #1;
            chk("tbl_empty", 64'(bus.empty_o), 64'd1);
            chk("tbl_wb_once", 64'(bus.wb_valid_o), 64'd0);
            @(negedge clk);
        end

        // ---------------- fill to full with TLB misses ----------------
        for (int i = 0; i < 4; i++) begin
            set_store(64'h10 + 64'(i) * 64'h100, 64'(i), 8'hFF, 2'd3, 3'(i));
            #1;
            chk("fill_ready", 64'(bus.ready_o), 64'd1);
            @(negedge clk);
        end
        set_store(64'hF00, 64'hFF, 8'hFF, 2'd3, 3'd4);
        #1;
        chk("full_ready", 64'(bus.ready_o), 64'd0);
        chk("full_count", 64'(bus.count_o), 64'd4);
        chk("full_treq", 64'(bus.translation_req_o), 64'd1);
        chk("full_vaddr", bus.vaddr_o, 64'h10);
        @(negedge clk);
        idle();
        #1;
        chk("full_hold_count", 64'(bus.count_o), 64'd4);
        chk("full_hold_treq", 64'(bus.translation_req_o), 64'd1);
        chk("full_hold_vaddr", bus.vaddr_o, 64'h10);
        @(negedge clk);
        drain(12);
        chk("fill_nwb", 64'(n_wb), 64'd4);
        for (int i = 0; i < 4; i++) chk("fill_tid", 64'(wb_tids[i]), 64'(i));
        #1;
        chk("fill_empty", 64'(bus.empty_o), 64'd1);
        @(negedge clk);

        // ---------------- exception on middle entry ----------------
        for (int i = 0; i < 3; i++) begin
            set_store(64'h500 + 64'(i) * 64'h8, 64'h77, 8'h01, 2'd0, 3'(i));
            @(negedge clk);
        end
        idle();
        k = 0; n_wb = 0; n_push = 0; n_bad = 0;
        for (int c = 0; c < 15; c++) begin
            bus.dtlb_hit_i = 1'b1;
            bus.sb_ready_i = 1'b1;
            bus.ex_valid_i = (k == 1);
            bus.paddr_i    = 56'h9000 + 56'(k);
            #1;
            if (bus.translation_req_o) k++;
            if (bus.sb_valid_o) begin
                n_push++;
                if (bus.sb_paddr_o == 56'h9001) n_bad++;
            end
            if (bus.wb_valid_o) begin
                if (n_wb < 8) begin
                    wb_tids[n_wb] = bus.wb_trans_id_o;
                    wb_exs[n_wb]  = bus.wb_ex_o;
                end
                n_wb++;
            end
            @(negedge clk);
        end
        idle();
        chk("ex_nwb", 64'(n_wb), 64'd3);
        chk("ex_npush", 64'(n_push), 64'd2);
        chk("ex_no_sb", 64'(n_bad), 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("ex_tid", 64'(wb_tids[i]), 64'(i));
            chk("ex_flag", 64'(wb_exs[i]), (i == 1) ? 64'd1 : 64'd0);
        end

        // ---------------- store-buffer backpressure ----------------
        set_store(64'h7002, 64'h1234, 8'h03, 2'd1, 3'd6);
        @(negedge clk);
        idle();
        bus.dtlb_hit_i = 1'b1;
        bus.paddr_i    = 56'h70_7002;
        @(negedge clk);
        idle();
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_sbv", 64'(bus.sb_valid_o), 64'd1);
            chk("bp_data", bus.sb_data_o, 64'h1234_0000);
            chk("bp_be", 64'(bus.sb_be_o), 64'h0C);
            chk("bp_paddr", 64'(bus.sb_paddr_o), 64'h70_7002);
            chk("bp_nowb", 64'(bus.wb_valid_o), 64'd0);
            @(negedge clk);
        end
        bus.sb_ready_i = 1'b1;
        #1;
        chk("bp_rel_wb", 64'(bus.wb_valid_o), 64'd1);
        chk("bp_rel_tid", 64'(bus.wb_trans_id_o), 64'd6);
        @(negedge clk);
        idle();
        #1;
        chk("bp_one_push", 64'(bus.sb_valid_o), 64'd0);
        chk("bp_empty", 64'(bus.empty_o), 64'd1);
        @(negedge clk);

        // ---------------- flush with 3 pending ----------------
        for (int i = 0; i < 3; i++) begin
            set_store(64'h800 + 64'(i), 64'h11, 8'h01, 2'd0, 3'(i));
            @(negedge clk);
        end
        idle();
        bus.dtlb_hit_i = 1'b1;
        @(negedge clk);
        set_store(64'h900, 64'h22, 8'h01, 2'd0, 3'd5);
        bus.flush_i    = 1'b1;
        bus.sb_ready_i = 1'b1;
        bus.dtlb_hit_i = 1'b1;
        #1;
        chk("fl_sbv", 64'(bus.sb_valid_o), 64'd0);
        chk("fl_wbv", 64'(bus.wb_valid_o), 64'd0);
        @(negedge clk);
        idle();
        #1;
        chk("fl_count", 64'(bus.count_o), 64'd0);
        chk("fl_empty", 64'(bus.empty_o), 64'd1);
        chk("fl_treq", 64'(bus.translation_req_o), 64'd0);
        chk("fl_wbv_after", 64'(bus.wb_valid_o), 64'd0);
        @(negedge clk);

        // ---------------- simultaneous enqueue / translate / issue ----------------
        set_store(64'hA00, 64'h1, 8'h01, 2'd0, 3'd1);
        @(negedge clk);
        set_store(64'hA08, 64'h2, 8'h01, 2'd0, 3'd2);
        bus.dtlb_hit_i = 1'b1;
        #1;
        chk("sim_count1", 64'(bus.count_o), 64'd1);
        @(negedge clk);
        set_store(64'hA10, 64'h3, 8'h01, 2'd0, 3'd3);
        bus.dtlb_hit_i = 1'b1;
        bus.sb_ready_i = 1'b1;
        #1;
        chk("sim_count2", 64'(bus.count_o), 64'd2);
        chk("sim_wbv", 64'(bus.wb_valid_o), 64'd1);
        chk("sim_tid", 64'(bus.wb_trans_id_o), 64'd1);
        chk("sim_treq", 64'(bus.translation_req_o), 64'd1);
        @(negedge clk);
        idle();
        #1;
        chk("sim_net", 64'(bus.count_o), 64'd2);
        @(negedge clk);
        drain(8);
        chk("sim_nwb", 64'(n_wb), 64'd2);
        chk("sim_tid2", 64'(wb_tids[0]), 64'd2);
        chk("sim_tid3", 64'(wb_tids[1]), 64'd3);

        // ---------------- reset mid-operation ----------------
        set_store(64'hB00, 64'h1, 8'h01, 2'd0, 3'd4);
        @(negedge clk);
        set_store(64'hB08, 64'h2, 8'h01, 2'd0, 3'd5);
        bus.dtlb_hit_i = 1'b1;
        @(negedge clk);
        idle();
        rst = 1'b1;
        bus.sb_ready_i = 1'b1;
        bus.dtlb_hit_i = 1'b1;
        #1;
        chk("mrst_wbv", 64'(bus.wb_valid_o), 64'd0);
        chk("mrst_sbv", 64'(bus.sb_valid_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        chk("mrst_count", 64'(bus.count_o), 64'd0);
        chk("mrst_empty", 64'(bus.empty_o), 64'd1);
        chk("mrst_treq", 64'(bus.translation_req_o), 64'd0);
        chk("mrst_wbv_after", 64'(bus.wb_valid_o), 64'd0);
        @(negedge clk);

        // ---------------- randomized traffic vs reference queue ----------------
        mq.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit          r_valid, r_hit, r_ex, r_rdy, r_flush, exp_ready, head_ok, exp_sbv, exp_wb;
            int          fu;
            int          off;
            ment_t       e;
            logic [63:0] sh_data;
            logic [7:0]  sh_be;

            r_valid = ($urandom_range(99) < 70);
            r_hit   = ($urandom_range(99) < 50);
            r_ex    = ($urandom_range(99) < 15);
            r_rdy   = ($urandom_range(99) < 60);
            r_flush = ($urandom_range(99) < 3);
            e.vaddr = {$urandom(), $urandom()};
            e.data  = {$urandom(), $urandom()};
            e.be    = 8'($urandom());
            e.size  = 2'($urandom_range(3));
            e.tid   = 3'($urandom_range(7));
            e.paddr = 56'h0;
            e.xl    = 1'b0;
            e.ex    = 1'b0;

            idle();
            bus.valid_i    = r_valid;
            bus.vaddr_i    = e.vaddr;
            bus.data_i     = e.data;
            bus.be_i       = e.be;
            bus.size_i     = e.size;
            bus.trans_id_i = e.tid;
            bus.dtlb_hit_i = r_hit;
            bus.ex_valid_i = r_ex;
            bus.paddr_i    = {$urandom(), $urandom()};
            bus.sb_ready_i = r_rdy;
            bus.flush_i    = r_flush;
            #1;

            fu = -1;
            for (int j = 0; j < mq.size(); j++) if (fu < 0 && !mq[j].xl) fu = j;
            exp_ready = (mq.size() < DEPTH);
            head_ok   = (mq.size() > 0) && mq[0].xl;
            exp_sbv   = head_ok && !mq[0].ex && !r_flush;
            exp_wb    = head_ok && !r_flush && (mq[0].ex || r_rdy);

            chk("rnd_ready", 64'(bus.ready_o), 64'(exp_ready));
            chk("rnd_count", 64'(bus.count_o), 64'(mq.size()));
            chk("rnd_empty", 64'(bus.empty_o), 64'(mq.size() == 0));
            chk("rnd_treq", 64'(bus.translation_req_o), 64'(fu >= 0));
            if (fu >= 0) chk("rnd_vaddr", bus.vaddr_o, mq[fu].vaddr);
            chk("rnd_sbv", 64'(bus.sb_valid_o), 64'(exp_sbv));
            if (exp_sbv) begin
                chk("rnd_paddr", 64'(bus.sb_paddr_o), 64'(mq[0].paddr));
                chk("rnd_data", bus.sb_data_o, mq[0].data);
                chk("rnd_be", 64'(bus.sb_be_o), 64'(mq[0].be));
                chk("rnd_size", 64'(bus.sb_size_o), 64'(mq[0].size));
            end
            chk("rnd_wbv", 64'(bus.wb_valid_o), 64'(exp_wb));
            if (exp_wb) begin
                chk("rnd_tid", 64'(bus.wb_trans_id_o), 64'(mq[0].tid));
                chk("rnd_wbex", 64'(bus.wb_ex_o), 64'(mq[0].ex));
            end

            if (r_flush) begin
                mq.delete();
            end else begin
                if (fu >= 0 && r_hit) begin
                    ment_t t;
                    t       = mq[fu];
                    t.xl    = 1'b1;
                    t.ex    = r_ex;
                    t.paddr = bus.paddr_i;
                    mq[fu]  = t;
                end
                if (exp_wb) void'(mq.pop_front());
                if (r_valid && exp_ready) begin
                    off     = int'(e.vaddr[2:0]);
                    sh_data = e.data << (8 * off);
                    sh_be   = e.be << off;
                    e.data  = sh_data;
                    e.be    = sh_be;
                    mq.push_back(e);
                end
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
